// File: rtl/icache.sv
// icache: direct-mapped instruction cache with one-word blocks.
// A hit returns the word in the same cycle. A miss runs a blocking,
// non-abortable fill from the memory controller.
// Optional feature: define ICACHE_PERF_EN to add the saturating
// hit_count and miss_count ports.
module icache #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic [0:0] {IDLE = 1'b0, MISS = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [SETS-1:0]     valid_r;
  logic [TAG_W-1:0]    tag_r  [SETS];
  logic [WORD_W-1:0]   data_r [SETS];
  logic [TAG_W-1:0]    miss_tag_r;
  logic [IDX_W-1:0]    miss_idx_r;

  logic [TAG_W-1:0]    tag_s;
  logic [IDX_W-1:0]    idx_s;
  logic                hit_s;
  logic                latch_s;
  logic                fill_s;
  logic                ihit_s;
  logic [WORD_W-1:0]   imemload_s;
  logic                iren_s;
  logic [WORD_W-1:0]   iaddr_s;
  logic                unused_s;

  assign tag_s    = imemaddr[WORD_W-1:IDX_W+2];
  assign idx_s    = imemaddr[IDX_W+1:2];
  assign hit_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign unused_s = ^imemaddr[1:0];

  // Next-state and output decode: lookup in IDLE, fill request in MISS.
  always_comb begin
    state_nxt_s = state_r;
    ihit_s      = 1'b0;
    imemload_s  = '0;
    iren_s      = 1'b0;
    iaddr_s     = '0;
    latch_s     = 1'b0;
    fill_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (imemREN) begin
          if (hit_s) begin
            ihit_s     = 1'b1;
            imemload_s = data_r[idx_s];
          end else begin
            latch_s     = 1'b1;
            state_nxt_s = MISS;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MISS: begin
        iren_s  = 1'b1;
        iaddr_s = {miss_tag_r, miss_idx_r, 2'b00};
        if (!iwait) begin
          fill_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MISS;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign ihit     = ihit_s;
  assign imemload = imemload_s;
  assign iREN     = iren_s;
  assign iaddr    = iaddr_s;

  // State, valid bits and the latched miss address (all cleared on reset).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r    <= IDLE;
      valid_r    <= '0;
      miss_tag_r <= '0;
      miss_idx_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (latch_s) begin
        miss_tag_r <= tag_s;
        miss_idx_r <= idx_s;
      end
      if (fill_s) begin
        valid_r[miss_idx_r] <= 1'b1;
      end
    end
  end

  // Tag and data storage; not reset because valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      tag_r[miss_idx_r]  <= miss_tag_r;
      data_r[miss_idx_r] <= iload;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Saturating performance counters for hit cycles and miss entries.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      if (ihit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (latch_s && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache. A behavioural model based on word
// addresses predicts every output on each falling edge. Hand-computed
// literal checks pin the documented scenarios.
module tb_icache;

  logic        CLK, nRST, imemREN, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache #(.SETS(16), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
`ifdef ICACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int mem_delay = 2;
  int wait_left = 0;
  int ren_cycles = 0;

  // Behavioural model: frames hold full word addresses; one pending fill.
  logic        m_valid [16];
  logic [29:0] m_waddr [16];
  logic [31:0] m_data  [16];
  logic        m_busy;
  logic [29:0] m_pend;
  logic [31:0] m_hits, m_misses;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h3C01_0001;
    else if (a == 32'h0000_0040) return 32'h2402_0002;
    else                         return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: iwait stays high for mem_delay cycles of each request.
  always @(posedge CLK) begin
    #2;
    if (iREN) begin
      if (wait_left > 0) begin
        iwait = 1'b1;
        iload = 32'h0;
        wait_left--;
      end else begin
        iwait = 1'b0;
        iload = mem_word(iaddr);
      end
    end else begin
      iwait = 1'b1;
      iload = 32'h0;
      wait_left = mem_delay;
    end
  end

  // Compare process: predicts outputs from the model and advances it.
  always @(negedge CLK) begin
    logic [3:0]  ix;
    logic        e_hit;
    logic [31:0] e_load;
    if (!nRST) begin
      chk("rst_ihit", {31'd0, ihit}, 32'd0);
      chk("rst_imemload", imemload, 32'd0);
      chk("rst_iren", {31'd0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
`ifdef ICACHE_PERF_EN
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
`endif
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_busy = 1'b0; m_pend = 30'd0; m_hits = 32'd0; m_misses = 32'd0;
    end else begin
`ifdef ICACHE_PERF_EN
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
`endif
      if (iREN) ren_cycles++;
      if (!m_busy) begin
        ix = imemaddr[5:2];
        e_hit  = imemREN && m_valid[ix] && (m_waddr[ix] == imemaddr[31:2]);
        e_load = e_hit ? m_data[ix] : 32'd0;
        chk("ihit", {31'd0, ihit}, {31'd0, e_hit});
        chk("imemload", imemload, e_load);
        chk("iren_idle", {31'd0, iREN}, 32'd0);
        chk("iaddr_idle", iaddr, 32'd0);
        if (e_hit && m_hits != 32'hFFFF_FFFF) m_hits++;
        if (imemREN && !e_hit) begin
          m_busy = 1'b1;
          m_pend = imemaddr[31:2];
          if (m_misses != 32'hFFFF_FFFF) m_misses++;
        end
      end else begin
        chk("ihit_miss", {31'd0, ihit}, 32'd0);
        chk("imemload_miss", imemload, 32'd0);
        chk("iren_miss", {31'd0, iREN}, 32'd1);
        chk("iaddr_miss", iaddr, {m_pend, 2'b00});
        if (!iwait) begin
          m_valid[m_pend[3:0]] = 1'b1;
          m_waddr[m_pend[3:0]] = m_pend;
          m_data[m_pend[3:0]]  = mem_word({m_pend, 2'b00});
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic en, input logic [31:0] a);
    @(posedge CLK); #1;
    imemREN = en; imemaddr = a;
  endtask

  // Waits (bounded) for a hit and checks the returned word.
  task automatic wait_hit(input string nm, input logic [31:0] exp, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge CLK);
      if (ihit) found = 1'b1;
    end
    chk({nm, "_hit_seen"}, {31'd0, found}, 32'd1);
    chk({nm, "_data"}, imemload, exp);
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    // Cold miss on 0x0 with two wait cycles.
    mem_delay = 2;
    drive(1'b1, 32'h0000_0000);
    ren_cycles = 0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("cold_ihit", {31'd0, ihit}, 32'd1);
    chk("cold_data", imemload, 32'h3C01_0001);
    chk("cold_ren_cycles", ren_cycles, 32'd3);
    // Warm hit on the following cycle.
    @(negedge CLK);
    chk("warm_ihit", {31'd0, ihit}, 32'd1);
    chk("warm_iren", {31'd0, iREN}, 32'd0);
    drive(1'b0, 32'h0000_0000);
    @(negedge CLK);
`ifdef ICACHE_PERF_EN
    chk("perf_hits", hit_count, 32'd2);
    chk("perf_misses", miss_count, 32'd1);
`endif

    // Conflict: 0x40 evicts 0x0 from frame 0.
    mem_delay = 1;
    drive(1'b1, 32'h0000_0040);
    wait_hit("conflict_40", 32'h2402_0002, 10);
    drive(1'b1, 32'h0000_0000);
    @(negedge CLK);
    chk("refetch0_miss", {31'd0, ihit}, 32'd0);
    wait_hit("refetch0", 32'h3C01_0001, 10);

    // Retarget mid-miss: the fill stays on 0x8.
    mem_delay = 3;
    drive(1'b1, 32'h0000_0008);
    drive(1'b1, 32'h0000_0010);
    @(negedge CLK);
    chk("retarget_iaddr", iaddr, 32'h0000_0008);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("retarget_new_miss", {31'd0, ihit}, 32'd0);
    @(negedge CLK);
    chk("retarget_iaddr10", iaddr, 32'h0000_0010);
    wait_hit("fill10", mem_word(32'h0000_0010), 12);
    drive(1'b1, 32'h0000_0008);
    @(negedge CLK);
    chk("hit8_ihit", {31'd0, ihit}, 32'd1);
    chk("hit8_data", imemload, 32'h0008_FFF7);

    // Reset during a miss.
    mem_delay = 4;
    drive(1'b1, 32'h0000_0014);
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1 chk("rst_mid_iren", {31'd0, iREN}, 32'd0);
    @(posedge CLK); #1 nRST = 1'b1;
    imemaddr = 32'h0000_0000;
    @(negedge CLK);
    chk("post_rst_miss", {31'd0, ihit}, 32'd0);
    wait_hit("post_rst", 32'h3C01_0001, 12);

    // Short sweep with mixed indices and byte offsets.
    mem_delay = 0;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      a = 32'h0000_1000 + k * 32'h44 + k[1:0];
      drive(1'b1, a);
      wait_hit("sweep", mem_word({a[31:2], 2'b00}), 8);
    end

    drive(1'b0, 32'h0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
